// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter.
//   lc3b_word       - address/data word
//   lc3b_mem_wmask  - byte-enable vector for one word
//   lc3b_arb_state  - arbiter FSM states
package lc3b_mem_arbiter_pkg;

  localparam int LC3B_DATA_WIDTH = 16;
  localparam int LC3B_MASK_WIDTH = LC3B_DATA_WIDTH / 8;

  typedef logic [LC3B_DATA_WIDTH-1:0] lc3b_word;
  typedef logic [LC3B_MASK_WIDTH-1:0] lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } lc3b_arb_state;

endpackage

// File: rtl/lc3b_mem_arbiter.sv
// Arbiter between the instruction-fetch port (I) and the MEM-stage data port
// (D) onto a single physical memory port. One transaction is in flight at a
// time; simultaneous requests are resolved round-robin (the client that did
// not win the previous grant wins the tie). Every pmem output is driven from
// a flop, and each granted transaction yields exactly one x_resp pulse.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   i_read, i_address                fetch request (held until i_resp)
//   i_resp, i_rdata                  fetch completion pulse + data
//   d_read, d_write, d_address,
//   d_wdata, d_wmask                 data request (held until d_resp)
//   d_resp, d_rdata                  data completion pulse + load data
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata,
//   pmem_wmask                       registered physical memory request
//   pmem_resp, pmem_rdata            physical memory completion + read data
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [MASK_WIDTH-1:0] d_wmask,
  output logic                  d_resp,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [DATA_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [MASK_WIDTH-1:0] pmem_wmask,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_state_next;

  // 1 = D won the most recent grant. Resets to I so the first tie goes to D.
  logic                  r_last_grant_d;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [DATA_WIDTH-1:0] r_pmem_address;
  logic [DATA_WIDTH-1:0] r_pmem_wdata;
  logic [MASK_WIDTH-1:0] r_pmem_wmask;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_req_i;
  logic w_req_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;

  assign w_req_i = i_read;
  assign w_req_d = d_read | d_write;
  assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);

  // D wins when it is alone, or on a tie when I won last time.
  assign w_grant_d = (r_state == IDLE) && w_req_d && (!w_req_i || !r_last_grant_d);
  assign w_grant_i = (r_state == IDLE) && w_req_i && !w_grant_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_next = BUSY_D;
        end else if (w_grant_i) begin
          w_state_next = BUSY_I;
        end
      end
      BUSY_I:  if (pmem_resp) w_state_next = DONE_I;
      BUSY_D:  if (pmem_resp) w_state_next = DONE_D;
      DONE_I:  w_state_next = IDLE;
      DONE_D:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture and read-data capture. Strobes rise the cycle after the
  // grant and fall the cycle after pmem_resp, so memory never sees client
  // inputs combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant_d <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_pmem_wmask   <= '0;
      r_rdata        <= '0;
    end else begin
      if (w_grant_d) begin
        // read+write together is treated as a write
        r_last_grant_d <= 1'b1;
        r_pmem_read    <= ~d_write;
        r_pmem_write   <= d_write;
        r_pmem_address <= d_address;
        r_pmem_wdata   <= d_wdata;
        r_pmem_wmask   <= d_write ? d_wmask : '1;
      end else if (w_grant_i) begin
        r_last_grant_d <= 1'b0;
        r_pmem_read    <= 1'b1;
        r_pmem_write   <= 1'b0;
        r_pmem_address <= i_address;
        r_pmem_wdata   <= '0;
        r_pmem_wmask   <= '1;
      end else if (w_busy && pmem_resp) begin
        r_pmem_read    <= 1'b0;
        r_pmem_write   <= 1'b0;
        r_rdata        <= pmem_rdata;
      end
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign pmem_wmask   = r_pmem_wmask;

  assign i_resp  = (r_state == DONE_I);
  assign d_resp  = (r_state == DONE_D);
  assign i_rdata = r_rdata;
  assign d_rdata = r_rdata;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter. A transaction-level model tracks
// the one outstanding transaction (who won, its fields, when memory answered)
// and derives the expected pin values each cycle. The bench also plays the
// memory, answering after a chosen number of wait cycles.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_address = '0;
  logic [15:0] d_wdata = '0;
  logic [1:0]  d_wmask = '0;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_resp = 1'b0;
  logic [15:0] pmem_rdata = '0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.DATA_WIDTH(16), .MASK_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          edge_n = 0;
  bit          t_active, t_done, t_is_d, t_write;
  logic [15:0] t_addr, t_wdata, t_rdata;
  logic [1:0]  t_wmask;
  int          resp_edge, free_edge;
  bit          last_d;
  int          wait_cnt;
  bit          grant_log[$];
  int          resps_i, resps_d;
  bit          ev_i_resp, ev_d_resp;
  // memory / stimulus knobs
  int          min_wait = 0, max_wait = 0;
  bit          fix_data = 1'b0;
  logic [15:0] fix_val = '0;
  bit          stray_en = 1'b0;

  task automatic model_reset();
    t_active  = 1'b0;
    t_done    = 1'b0;
    last_d    = 1'b0;
    free_edge = 0;
    ev_i_resp = 1'b0;
    ev_d_resp = 1'b0;
  endtask

  task automatic drive_mem();
    if (t_active && !t_done) begin
      if (wait_cnt == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = fix_data ? fix_val : 16'($urandom);
      end else begin
        wait_cnt--;
        pmem_resp  = 1'b0;
        pmem_rdata = 16'($urandom);
      end
    end else begin
      pmem_resp  = stray_en && ($urandom_range(0, 3) == 0);
      pmem_rdata = 16'($urandom);
    end
  endtask

  task automatic compare();
    bit strobe;
    strobe    = t_active && !t_done;
    ev_i_resp = t_active && t_done && !t_is_d && (edge_n == resp_edge);
    ev_d_resp = t_active && t_done &&  t_is_d && (edge_n == resp_edge);
    check_val("pmem_read", pmem_read, strobe && !t_write);
    check_val("pmem_write", pmem_write, strobe && t_write);
    check_val("i_resp", i_resp, ev_i_resp);
    check_val("d_resp", d_resp, ev_d_resp);
    if (strobe) begin
      check_val("pmem_address", pmem_address, t_addr);
      check_val("pmem_wmask", pmem_wmask, t_wmask);
      if (t_write) check_val("pmem_wdata", pmem_wdata, t_wdata);
    end
    if (ev_i_resp) check_val("i_rdata", i_rdata, t_rdata);
    if (ev_d_resp && !t_write) check_val("d_rdata", d_rdata, t_rdata);
    resps_i += int'(i_resp);
    resps_d += int'(d_resp);
  endtask

  // One clock: apply the arbitration rules to the inputs seen at the edge,
  // then compare, then let memory react.
  task automatic step();
    bit want_i, want_d, pick_d;
    @(posedge clk);
    edge_n++;
    if (reset_n) begin
      if (t_active && !t_done && pmem_resp) begin
        t_done    = 1'b1;
        t_rdata   = pmem_rdata;
        resp_edge = edge_n;
        free_edge = edge_n + 2;
      end else if (t_active && t_done && edge_n > resp_edge) begin
        t_active = 1'b0;
      end
      if (!t_active && edge_n >= free_edge) begin
        want_i = i_read;
        want_d = d_read | d_write;
        if (want_i || want_d) begin
          pick_d   = want_d && (!want_i || !last_d);
          last_d   = pick_d;
          t_active = 1'b1;
          t_done   = 1'b0;
          t_is_d   = pick_d;
          t_write  = pick_d && d_write;
          t_addr   = pick_d ? d_address : i_address;
          t_wdata  = d_wdata;
          t_wmask  = t_write ? d_wmask : 2'b11;
          wait_cnt = $urandom_range(max_wait, min_wait);
          grant_log.push_back(pick_d);
        end
      end
    end
    #1;
    compare();
    drive_mem();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd"}, pmem_read, 0);
    check_val({tag, "_wr"}, pmem_write, 0);
    check_val({tag, "_iresp"}, i_resp, 0);
    check_val({tag, "_dresp"}, d_resp, 0);
    check_val({tag, "_addr"}, pmem_address, 0);
    check_val({tag, "_wdata"}, pmem_wdata, 0);
    check_val({tag, "_wmask"}, pmem_wmask, 0);
    check_val({tag, "_rdata"}, i_rdata, 0);
  endtask

  // Asynchronous reset pulse taken between clock edges, held over one edge.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    pmem_resp = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (t_active && n < 60) begin
      step();
      n++;
    end
    check_val("drain_bound", t_active, 0);
  endtask

  task automatic drive_clients();
    int op;
    if (i_read) begin
      if (ev_i_resp) begin
        i_read    = 1'($urandom_range(0, 1));
        i_address = 16'($urandom);
      end else if ($urandom_range(0, 31) == 0) begin
        i_read = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      i_read    = 1'b1;
      i_address = 16'($urandom);
    end
    if (d_read || d_write) begin
      if (ev_d_resp || $urandom_range(0, 31) == 0) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      op        = $urandom_range(0, 2);
      d_read    = (op != 1);
      d_write   = (op != 0);
      d_address = 16'($urandom);
      d_wdata   = 16'($urandom);
      d_wmask   = 2'($urandom);
    end
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();

    // Contention held from reset: D, I, D, I
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0300;
    reset_n = 1'b1;
    grant_log.delete();
    repeat (14) step();
    check_val("cont_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      check_val("cont_g0", grant_log[0], 1);
      check_val("cont_g1", grant_log[1], 0);
      check_val("cont_g2", grant_log[2], 1);
      check_val("cont_g3", grant_log[3], 0);
    end
    i_read = 1'b0; d_read = 1'b0;
    drain();
    step();
    step();

    // I-only fetch, zero-wait memory
    resps_i = 0; resps_d = 0;
    fix_data = 1'b1; fix_val = 16'h1234;
    i_read = 1'b1; i_address = 16'h0010;
    step();
    check_val("ionly_read", pmem_read, 1);
    check_val("ionly_addr", pmem_address, 16'h0010);
    step();
    check_val("ionly_resp", i_resp, 1);
    check_val("ionly_rdata", i_rdata, 16'h1234);
    i_read = 1'b0;
    drain();
    step();
    check_val("ionly_no_dresp", resps_d, 0);
    check_val("ionly_one_iresp", resps_i, 1);
    fix_data = 1'b0;

    // D write
    resps_d = 0;
    d_write = 1'b1; d_address = 16'h0200; d_wdata = 16'hBEEF; d_wmask = 2'b10;
    step();
    check_val("dw_write", pmem_write, 1);
    check_val("dw_read", pmem_read, 0);
    check_val("dw_addr", pmem_address, 16'h0200);
    check_val("dw_wdata", pmem_wdata, 16'hBEEF);
    check_val("dw_wmask", pmem_wmask, 2'b10);
    step();
    check_val("dw_resp", d_resp, 1);
    d_write = 1'b0;
    drain();
    step();
    check_val("dw_one_resp", resps_d, 1);

    // Five wait states
    min_wait = 5; max_wait = 5;
    i_read = 1'b1; i_address = 16'h0042;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("wait_strobe", pmem_read, 1);
      check_val("wait_addr", pmem_address, 16'h0042);
      check_val("wait_noresp", i_resp, 0);
    end
    step();
    check_val("wait_resp", i_resp, 1);
    i_read = 1'b0;
    drain();
    step();

    // Reset during a D transaction, then a tie must go to D
    resps_d = 0;
    d_read = 1'b1; d_address = 16'h0123;
    step();
    step();
    check_val("rst_busy", pmem_read, 1);
    reset_pulse();
    check_val("rst_no_dresp", resps_d, 0);
    min_wait = 0; max_wait = 0;
    i_read = 1'b1; i_address = 16'h0456;
    grant_log.delete();
    step();
    check_val("rst_tie_size", grant_log.size(), 1);
    if (grant_log.size() == 1) check_val("rst_tie_d", grant_log[0], 1);
    check_val("rst_tie_addr", pmem_address, 16'h0123);
    i_read = 1'b0; d_read = 1'b0;
    drain();
    step();

    // Stray pmem_resp in IDLE, then client drops mid-transaction
    resps_i = 0; resps_d = 0;
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b1;
    step();
    check_val("stray_no_resp", resps_i + resps_d, 0);
    min_wait = 3; max_wait = 3;
    i_read = 1'b1; i_address = 16'h0077;
    step();
    i_read = 1'b0;
    drain();
    step();
    check_val("drop_iresp", resps_i, 1);

    // Randomized traffic with wait states, stray responses and resets
    min_wait = 0; max_wait = 4; stray_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      step();
      if ($urandom_range(0, 199) == 0) reset_pulse();
      drive_clients();
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    drain();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
